// File: rtl/lc3_exec_unit_if.sv
// lc3_exec_unit_if: issue handshake and register-file port bundle
// for the LC-3 operate-instruction execute stage.
interface lc3_exec_unit_if #(
    parameter int WIDTH = 16
);
    logic             issue_valid;
    logic             issue_ready;
    logic [WIDTH-1:0] ir;
    logic [2:0]       sr1;
    logic [2:0]       sr2;
    logic [WIDTH-1:0] sr1_data;
    logic [WIDTH-1:0] sr2_data;
    logic [2:0]       dr;
    logic             ld_reg;
    logic [WIDTH-1:0] bus_out;
    logic [2:0]       nzp;
    logic             done;
    logic             illegal;

    modport master (
        output issue_valid, ir, sr1_data, sr2_data,
        input  issue_ready, sr1, sr2, dr, ld_reg,
        input  bus_out, nzp, done, illegal
    );

    modport slave (
        input  issue_valid, ir, sr1_data, sr2_data,
        output issue_ready, sr1, sr2, dr, ld_reg,
        output bus_out, nzp, done, illegal
    );
endinterface

// File: rtl/lc3_exec_unit.sv
// lc3_exec_unit: multi-cycle LC-3 ADD/AND/NOT execute stage that
// drives the register file selects, write-back and NZP codes.
module lc3_exec_unit #(
    parameter int WIDTH = 16
) (
    input logic             clk,
    input logic             rst_n,
    lc3_exec_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        RD,
        EX,
        WB
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] ir_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] alu;
    logic [2:0]       nzp_q;
    logic             ld_q;
    logic             done_q;
    logic             ill_q;
    logic             is_add;
    logic             is_and;
    logic             is_not;
    logic             legal;
    logic             accept;

    assign accept = (state_q == IDLE) && bus.issue_valid;

    // Opcode decode of the latched instruction
    always_comb begin
        is_add = (ir_q[15:12] == 4'b0001);
        is_and = (ir_q[15:12] == 4'b0101);
        is_not = (ir_q[15:12] == 4'b1001);
        legal  = is_add | is_and | is_not;
    end

    // Operand select and ALU, valid while in EX
    always_comb begin
        opb = ir_q[5] ? {{(WIDTH-5){ir_q[4]}}, ir_q[4:0]}
                      : bus.sr2_data;
        alu = '0;
        unique case (1'b1)
            is_add:  alu = bus.sr1_data + opb;
            is_and:  alu = bus.sr1_data & opb;
            is_not:  alu = ~bus.sr1_data;
            default: alu = '0;
        endcase
    end

    // Next-state sequencing: fixed RD/EX/WB walk after an accept
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.issue_valid) state_d = RD;
            RD:      state_d = EX;
            EX:      state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Instruction latch, result capture and registered WB pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q     <= '0;
            result_q <= '0;
            ld_q     <= 1'b0;
            done_q   <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            if (accept) ir_q <= bus.ir;
            if (state_q == EX && legal) result_q <= alu;
            ld_q   <= (state_q == EX) && legal;
            done_q <= (state_q == EX);
            ill_q  <= (state_q == EX) && !legal;
        end
    end

    // Condition codes follow each committed write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzp_q <= 3'b010;
        end else if (state_q == WB && ld_q) begin
            if (result_q[WIDTH-1])  nzp_q <= 3'b100;
            else if (result_q == '0) nzp_q <= 3'b010;
            else                     nzp_q <= 3'b001;
        end
    end

    assign bus.issue_ready = (state_q == IDLE);
    assign bus.sr1         = ir_q[8:6];
    assign bus.sr2         = ir_q[2:0];
    assign bus.dr          = ir_q[11:9];
    assign bus.bus_out     = result_q;
    assign bus.ld_reg      = ld_q;
    assign bus.done        = done_q;
    assign bus.illegal     = ill_q;
    assign bus.nzp         = nzp_q;
endmodule

// File: tb/tb_lc3_exec_unit.sv
// tb_lc3_exec_unit: directed and random instructions against an
// instruction-level LC-3 model, with a behavioural 8x16 register file.
module tb_lc3_exec_unit;
    logic clk;
    logic rst_n;

    lc3_exec_unit_if #(.WIDTH(16)) u_if ();

    lc3_exec_unit #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    logic [15:0] rf [8];
    logic        poke_en;
    logic [2:0]  poke_addr;
    logic [15:0] poke_data;

    logic [15:0] exp_regs [8];
    logic [2:0]  exp_nzp;
    logic [15:0] last_res;

    int n_vec = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file environment: 1-cycle registered reads
    always @(posedge clk) begin
        u_if.sr1_data <= rf[u_if.sr1];
        u_if.sr2_data <= rf[u_if.sr2];
        if (u_if.ld_reg) rf[u_if.dr] <= u_if.bus_out;
        if (poke_en) rf[poke_addr] <= poke_data;
    end

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void compute(input logic [15:0] instr,
                                    output bit legal,
                                    output logic [15:0] res);
        int a;
        int b;
        a = int'(exp_regs[instr[8:6]]);
        if (instr[5]) b = int'($signed(instr[4:0]));
        else          b = int'(exp_regs[instr[2:0]]);
        legal = 1'b1;
        res   = last_res;
        case (instr[15:12])
            4'h1:    res = 16'(a + b);
            4'h5:    res = 16'(a & b);
            4'h9:    res = 16'(~a);
            default: legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] cc(input logic [15:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 16'd0)     return 3'b010;
        return 3'b001;
    endfunction

    task automatic poke(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        @(posedge clk);
        #1 poke_en = 1'b0;
        exp_regs[a] = d;
    endtask

    task automatic start(input logic [15:0] instr);
        int w;
        w = 0;
        @(negedge clk);
        while (!u_if.issue_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) begin
            n_vec++;
            n_bad++;
            $display("FAIL ready_timeout got=0 exp=1");
        end
        u_if.issue_valid = 1'b1;
        u_if.ir          = instr;
        @(posedge clk);
    endtask

    // Called just after the accept edge; checks through WB and commit
    task automatic follow(input logic [15:0] instr,
                          input logic [15:0] nxt, input bit hold);
        bit          legal;
        logic [15:0] res;
        logic [2:0]  d;
        compute(instr, legal, res);
        d = instr[11:9];
        #1;
        if (hold) u_if.ir = nxt;
        else      u_if.issue_valid = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            chk("ready_busy", 16'(u_if.issue_ready), 16'd0);
            chk("done", 16'(u_if.done), 16'(n == 3));
            chk("ld_reg", 16'(u_if.ld_reg), 16'(n == 3 && legal));
            chk("illegal", 16'(u_if.illegal), 16'(n == 3 && !legal));
            chk("sr1", 16'(u_if.sr1), 16'(instr[8:6]));
            chk("sr2", 16'(u_if.sr2), 16'(instr[2:0]));
            if (n == 3) begin
                chk("dr", 16'(u_if.dr), 16'(d));
                chk("bus_out", u_if.bus_out, res);
            end
        end
        if (legal) begin
            exp_regs[d] = res;
            exp_nzp     = cc(res);
            last_res    = res;
        end
        @(negedge clk);
        chk("ready_back", 16'(u_if.issue_ready), 16'd1);
        chk("done_after", 16'(u_if.done), 16'd0);
        chk("nzp", 16'(u_if.nzp), 16'(exp_nzp));
        chk("rf_write", rf[d], exp_regs[d]);
    endtask

    task automatic run(input logic [15:0] instr);
        start(instr);
        follow(instr, 16'h0, 1'b0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [15:0] instr;
        logic [15:0] r3_keep;
        rst_n            = 1'b0;
        u_if.issue_valid = 1'b0;
        u_if.ir          = 16'h0;
        poke_en          = 1'b0;
        poke_addr        = 3'd0;
        poke_data        = 16'h0;
        exp_nzp          = 3'b010;
        last_res         = 16'h0;
        for (int i = 0; i < 8; i++) exp_regs[i] = 16'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 16'(u_if.issue_ready), 16'd1);
        chk("rst_nzp", 16'(u_if.nzp), 16'h2);
        chk("rst_ld", 16'(u_if.ld_reg), 16'd0);
        chk("rst_done", 16'(u_if.done), 16'd0);
        chk("rst_ill", 16'(u_if.illegal), 16'd0);
        chk("rst_bus", u_if.bus_out, 16'h0);
        chk("rst_sel", 16'({u_if.sr1, u_if.sr2, u_if.dr}), 16'h0);

        for (int i = 0; i < 8; i++) poke(3'(i), 16'h0);
        poke(3'd1, 16'h0005);
        poke(3'd2, 16'h0003);
        poke(3'd7, 16'h7FFF);

        run(16'h1642);
        run(16'h187B);
        run(16'h9CBF);
        run(16'h1FE1);
        run(16'h1FE1);
        run(16'h1642);
        run(16'h0000);

        // issue_valid held high across two instructions
        start(16'h1642);
        follow(16'h1642, 16'h187B, 1'b1);
        @(posedge clk);
        follow(16'h187B, 16'h0, 1'b0);

        for (int i = 0; i < 8; i++) poke(3'(i), 16'($urandom));
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       op = 4'h1;
                1:       op = 4'h5;
                2:       op = 4'h9;
                default: op = 4'($urandom);
            endcase
            instr = {op, 12'($urandom)};
            run(instr);
        end

        // reset asserted while 0x1642 is in EX
        r3_keep = exp_regs[3];
        start(16'h1642);
        #1 u_if.issue_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ld", 16'(u_if.ld_reg), 16'd0);
        chk("mid_rst_done", 16'(u_if.done), 16'd0);
        chk("mid_rst_nzp", 16'(u_if.nzp), 16'h2);
        exp_nzp  = 3'b010;
        last_res = 16'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_ready", 16'(u_if.issue_ready), 16'd1);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("post_rst_done", 16'(u_if.done), 16'd0);
            chk("post_rst_ld", 16'(u_if.ld_reg), 16'd0);
        end
        chk("post_rst_r3", rf[3], r3_keep);
        chk("post_rst_nzp", 16'(u_if.nzp), 16'h2);
        run(16'h1642);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
